// File: rtl/uart_autobaud.sv
// uart_autobaud: measures a 0x55 sync character on RX and generates the 16x oversampling tick
//   clk       system clock
//   reset     synchronous active-high reset
//   iStart    single-cycle measurement request, ignored while oBusy
//   iRx       raw asynchronous RX line, idle high
//   oBusy     measurement in progress
//   oDone     one-cycle pulse on a successful measurement
//   oErr      one-cycle pulse on a failed measurement
//   oDivisor  current oversampling divisor
//   oLocked   at least one measurement has succeeded since reset
//   oTick     one-cycle oversampling tick every oDivisor clocks while locked
//   Optional: define AUTOBAUD_CHECK_EN to reject frames whose edge intervals deviate from the first by more than 25%
module uart_autobaud #(
   parameter int CNT_W = 20,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             iStart,
   input  logic             iRx,
   output logic             oBusy,
   output logic             oDone,
   output logic             oErr,
   output logic [DIV_W-1:0] oDivisor,
   output logic             oLocked,
   output logic             oTick
);
   typedef enum logic [1:0] {IDLE, ARM, MEASURE, CALC} state_t;
   state_t state;
   logic rx_s1, rx_s2, rx_d, fall, interval_bad, d_ok;
   logic [CNT_W-1:0] cnt, cnt_inc, t_meas;
   logic [CNT_W-7:0] d_full;
   logic [1:0] edges;
   logic [DIV_W-1:0] tick_cnt;
   assign fall = rx_d & ~rx_s2;
   assign cnt_inc = cnt + 1'b1;
   // rounding add one bit wider than the counter so it never wraps
   assign d_full = (CNT_W-6)'(({1'b0, t_meas} + (CNT_W+1)'(64)) >> 7);
   assign d_ok = (|d_full) && ~|(d_full >> DIV_W);
`ifdef AUTOBAUD_CHECK_EN
   logic [CNT_W-1:0] i1, last_pos, ik, dev;
   // edge positions are expressed as cnt+1, with the first edge at 0
   assign ik = cnt_inc - last_pos;
   assign dev = ik >= i1 ? ik - i1 : i1 - ik;
   assign interval_bad = edges != 2'd0 && dev > (i1 >> 2);
`else
   assign interval_bad = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_d     <= 1'b1;
         oBusy    <= 1'b0;
         oDone    <= 1'b0;
         oErr     <= 1'b0;
         oDivisor <= '0;
         oLocked  <= 1'b0;
         oTick    <= 1'b0;
         tick_cnt <= '0;
         cnt      <= '0;
         t_meas   <= '0;
         edges    <= '0;
`ifdef AUTOBAUD_CHECK_EN
         i1       <= '0;
         last_pos <= '0;
`endif
      end else begin
         rx_s1 <= iRx;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
         oDone <= 1'b0;
         oErr  <= 1'b0;
         oTick    <= oLocked && tick_cnt == '0;
         tick_cnt <= !oLocked ? tick_cnt : tick_cnt == '0 ? oDivisor - 1'b1 : tick_cnt - 1'b1;
         case (state)
            IDLE: if (iStart) begin
               state <= ARM;
               oBusy <= 1'b1;
            end
            ARM: if (fall) begin
               cnt   <= '0;
               edges <= '0;
               state <= MEASURE;
            end
            MEASURE: begin
               cnt <= cnt_inc;
               if (fall && interval_bad) begin
                  oErr  <= 1'b1;
                  oBusy <= 1'b0;
                  state <= IDLE;
               end else if (fall) begin
                  edges <= edges + 1'b1;
`ifdef AUTOBAUD_CHECK_EN
                  last_pos <= cnt_inc;
                  if (edges == 2'd0) i1 <= cnt_inc;
`endif
                  if (edges == 2'd3) begin
                     t_meas <= cnt_inc;
                     state  <= CALC;
                  end
               end else if (&cnt) begin
                  oErr  <= 1'b1;
                  oBusy <= 1'b0;
                  state <= IDLE;
               end
            end
            CALC: begin
               state <= IDLE;
               oBusy <= 1'b0;
               if (d_ok) begin
                  oDivisor <= DIV_W'(d_full);
                  oLocked  <= 1'b1;
                  oDone    <= 1'b1;
                  // restart the tick phase on the new divisor, suppressing a tick in the load cycle
                  tick_cnt <= DIV_W'(d_full) - 1'b1;
                  oTick    <= 1'b0;
               end else begin
                  oErr <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: directed bench for uart_autobaud (main instance plus a CNT_W=12 instance for timeout)
`timescale 1ns/1ps
module tb_uart_autobaud;
   logic clk = 1'b0;
   logic reset, start, rx, busy, done, err, locked, tick;
   logic [7:0] div;
   logic start_t, rx_t, busy_t, done_t, err_t, locked_t, tick_t;
   logic [7:0] div_t;
   int vectors = 0, miscompares = 0;
   int cyc = 0, n_done = 0, n_err = 0, done_cyc = 0;
   always #10 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (err) n_err++;
   end
   uart_autobaud dut (
      .clk(clk), .reset(reset), .iStart(start), .iRx(rx), .oBusy(busy), .oDone(done),
      .oErr(err), .oDivisor(div), .oLocked(locked), .oTick(tick)
   );
   uart_autobaud #(.CNT_W(12)) dut_t (
      .clk(clk), .reset(reset), .iStart(start_t), .iRx(rx_t), .oBusy(busy_t), .oDone(done_t),
      .oErr(err_t), .oDivisor(div_t), .oLocked(locked_t), .oTick(tick_t)
   );
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask
   // slots 0..8 of a 0x55 frame alternate low/high starting with the start bit; slot 8 is kept to 1 cycle
   task automatic send_frame(input int p, input int sslot, input int sext, input int nslots);
      int len;
      for (int s = 0; s < nslots; s++) begin
         rx = s[0];
         len = (s == 8) ? 1 : p + ((s == sslot) ? sext : 0);
         repeat (len) @(negedge clk);
      end
      rx = 1'b1;
   endtask
   task automatic wait_tick(input int lim, output int t);
      t = -1;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (tick) begin
            t = cyc;
            return;
         end
      end
   endtask
   task automatic test_reset();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
      vectors++; if (div !== 8'd0) begin miscompares++; $display("FAIL reset_div: got %0d want 0", div); end
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b want 0", locked); end
      vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b want 0", tick); end
   endtask
   task automatic test_timeout();
      int c0, ec, nd;
      ec = -1;
      nd = 0;
      start_t = 1'b1;
      @(negedge clk);
      start_t = 1'b0;
      vectors++; if (busy_t !== 1'b1) begin miscompares++; $display("FAIL to_busy: got %b want 1", busy_t); end
      idle(5);
      rx_t = 1'b0;
      c0 = cyc;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (done_t) nd++;
         if (err_t) begin
            ec = cyc;
            break;
         end
      end
      vectors++; if (ec - c0 !== 4099) begin miscompares++; $display("FAIL to_latency: got %0d want 4099", ec - c0); end
      vectors++; if (nd !== 0) begin miscompares++; $display("FAIL to_nodone: got %0d want 0", nd); end
      @(negedge clk);
      vectors++; if (err_t !== 1'b0) begin miscompares++; $display("FAIL to_errpulse: got %b want 0", err_t); end
      vectors++; if (busy_t !== 1'b0) begin miscompares++; $display("FAIL to_busy_end: got %b want 0", busy_t); end
      vectors++; if (locked_t !== 1'b0) begin miscompares++; $display("FAIL to_locked: got %b want 0", locked_t); end
      rx_t = 1'b1;
   endtask
   task automatic test_range_9600();
      int d0, e0, nt;
      d0 = n_done;
      e0 = n_err;
      nt = 0;
      pulse_start();
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL r96_busy: got %b want 1", busy); end
      send_frame(5208, -1, 0, 9);
      idle(10);
      vectors++; if (n_err !== e0 + 1) begin miscompares++; $display("FAIL r96_err: got %0d want %0d", n_err, e0 + 1); end
      vectors++; if (n_done !== d0) begin miscompares++; $display("FAIL r96_done: got %0d want %0d", n_done, d0); end
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL r96_locked: got %b want 0", locked); end
      vectors++; if (div !== 8'd0) begin miscompares++; $display("FAIL r96_div: got %0d want 0", div); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL r96_busy_end: got %b want 0", busy); end
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tick) nt++;
      end
      vectors++; if (nt !== 0) begin miscompares++; $display("FAIL r96_tick: got %0d want 0", nt); end
   endtask
   task automatic test_lock_38400();
      int d0, e0, t, t_prev;
      d0 = n_done;
      e0 = n_err;
      pulse_start();
      send_frame(1302, -1, 0, 9);
      idle(10);
      vectors++; if (n_done !== d0 + 1) begin miscompares++; $display("FAIL l384_done: got %0d want %0d", n_done, d0 + 1); end
      vectors++; if (n_err !== e0) begin miscompares++; $display("FAIL l384_err: got %0d want %0d", n_err, e0); end
      vectors++; if (div !== 8'd81) begin miscompares++; $display("FAIL l384_div: got %0d want 81", div); end
      vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL l384_locked: got %b want 1", locked); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL l384_busy: got %b want 0", busy); end
      wait_tick(300, t);
      vectors++; if (t - done_cyc !== 81) begin miscompares++; $display("FAIL l384_first_tick: got %0d want 81", t - done_cyc); end
      for (int k = 0; k < 3; k++) begin
         t_prev = t;
         wait_tick(300, t);
         vectors++; if (t - t_prev !== 81) begin miscompares++; $display("FAIL l384_period%0d: got %0d want 81", k, t - t_prev); end
      end
   endtask
   task automatic test_remeasure();
      int last, bad, nt, load, t1, t2;
      logic got, tick_at_load;
      logic [7:0] div_at_load;
      last = -1;
      bad = 0;
      nt = 0;
      load = 0;
      got = 1'b0;
      tick_at_load = 1'b1;
      div_at_load = 8'd0;
      pulse_start();
      fork
         send_frame(434, -1, 0, 9);
         for (int i = 0; i < 8000 && !got; i++) begin
            @(negedge clk);
            if (done) begin
               got = 1'b1;
               load = cyc;
               tick_at_load = tick;
               div_at_load = div;
            end else if (tick) begin
               if (last >= 0 && cyc - last != 81) bad++;
               last = cyc;
               nt++;
            end
         end
      join
      vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL rm_done: got %b want 1", got); end
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rm_old_period: got %0d off-period ticks want 0", bad); end
      vectors++; if (nt < 30) begin miscompares++; $display("FAIL rm_old_ticks: got %0d want >=30", nt); end
      vectors++; if (tick_at_load !== 1'b0) begin miscompares++; $display("FAIL rm_load_tick: got %b want 0", tick_at_load); end
      vectors++; if (div_at_load !== 8'd27) begin miscompares++; $display("FAIL rm_div: got %0d want 27", div_at_load); end
      wait_tick(300, t1);
      vectors++; if (t1 - load !== 27) begin miscompares++; $display("FAIL rm_first_tick: got %0d want 27", t1 - load); end
      wait_tick(300, t2);
      vectors++; if (t2 - t1 !== 27) begin miscompares++; $display("FAIL rm_period: got %0d want 27", t2 - t1); end
   endtask
   task automatic test_reset_mid();
      int d0, e0;
      pulse_start();
      send_frame(434, -1, 0, 4);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      d0 = n_done;
      e0 = n_err;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", busy); end
      vectors++; if (div !== 8'd0) begin miscompares++; $display("FAIL rmid_div: got %0d want 0", div); end
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rmid_locked: got %b want 0", locked); end
      vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL rmid_tick: got %b want 0", tick); end
      idle(3000);
      vectors++; if (n_done + n_err !== d0 + e0) begin miscompares++; $display("FAIL rmid_pulses: got %0d want %0d", n_done + n_err, d0 + e0); end
      pulse_start();
      send_frame(434, -1, 0, 9);
      idle(10);
      vectors++; if (n_done !== d0 + 1) begin miscompares++; $display("FAIL rmid_relock: got %0d want %0d", n_done, d0 + 1); end
      vectors++; if (div !== 8'd27) begin miscompares++; $display("FAIL rmid_div2: got %0d want 27", div); end
      vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL rmid_locked2: got %b want 1", locked); end
   endtask
   task automatic test_stretch();
      int d0, e0;
      d0 = n_done;
      e0 = n_err;
      pulse_start();
      send_frame(1303, 2, 652, 9);
      idle(10);
`ifdef AUTOBAUD_CHECK_EN
      vectors++; if (n_err !== e0 + 1) begin miscompares++; $display("FAIL st_err: got %0d want %0d", n_err, e0 + 1); end
      vectors++; if (n_done !== d0) begin miscompares++; $display("FAIL st_done: got %0d want %0d", n_done, d0); end
      vectors++; if (div !== 8'd27) begin miscompares++; $display("FAIL st_div: got %0d want 27", div); end
`else
      vectors++; if (n_done !== d0 + 1) begin miscompares++; $display("FAIL st_done: got %0d want %0d", n_done, d0 + 1); end
      vectors++; if (n_err !== e0) begin miscompares++; $display("FAIL st_err: got %0d want %0d", n_err, e0); end
      vectors++; if (div !== 8'd87) begin miscompares++; $display("FAIL st_div: got %0d want 87", div); end
`endif
   endtask
   initial begin
      reset = 1'b1;
      start = 1'b0;
      rx = 1'b1;
      start_t = 1'b0;
      rx_t = 1'b1;
      idle(3);
      reset = 1'b0;
      test_reset();
      test_timeout();
      test_range_9600();
      test_lock_38400();
      test_remeasure();
      test_reset_mid();
      test_stretch();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
